// File: rtl/uart_rx_os_if.sv
// Output handshake bundle of the oversampling UART receiver.
// The receiver drives the held frame and its flags; the consumer drives data_ready.
interface uart_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output data_out,
      output data_valid,
      output parity_err,
      output frame_err,
      output overrun,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      input  parity_err,
      input  frame_err,
      input  overrun,
      output data_ready
   );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a one-entry valid/ready output register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle; wait for a falling edge once re-armed by rxs=1
// S_START  | validate start bit at half a bit period
// S_DATA   | sample DATA_BITS data bits at mid-bit, LSB first
// S_PARITY | sample the parity bit at mid-bit
// S_STOP   | sample STOP_BITS stop bits; last one completes the frame
module uart_rx_os #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx_pin,
   input  logic         os_tick,
   uart_rx_os_if.master rx_if
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = ($clog2(DATA_BITS) < 1) ? 1 : $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 pbit_q, pbit_d;
   logic                 ferr_q, ferr_d;
   logic                 done_q, done_d;
   logic                 armed_q, armed_d;

   logic                 sync1_q, sync2_q;
   logic                 rxs;

   logic [DATA_BITS-1:0] dout_q;
   logic                 valid_q;
   logic                 perr_out_q;
   logic                 ferr_out_q;
   logic                 ovr_q;

   logic                 par_xor;
   logic                 perr_w;

   assign rxs = sync2_q;

   // Two-flop synchroniser for the asynchronous line; resets to idle-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_pin;
         sync2_q <= sync1_q;
      end
   end

   // Receive FSM and counter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         pbit_q  <= 1'b0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         pbit_q  <= pbit_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         armed_q <= armed_d;
      end
   end

   // Next-state logic; everything but the arming flag moves only on os_tick.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      pbit_d  = pbit_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      armed_d = armed_q | rxs;

      if (os_tick) begin
         case (state_q)
            S_IDLE: begin
               if (armed_q && !rxs) begin
                  state_d = S_START;
                  tick_d  = '0;
               end
            end
            S_START: begin
               if (tick_q == TICK_HALF) begin
                  if (rxs) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                     ferr_d  = 1'b0;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_DATA: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                  if (bit_q == DATA_LAST) begin
                     bit_d   = '0;
                     state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_PARITY: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  pbit_d  = rxs;
                  bit_d   = '0;
                  state_d = S_STOP;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_STOP: begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (!rxs) begin
                     ferr_d = 1'b1;
                  end
                  if (bit_q == STOP_LAST) begin
                     // A break still low here must not start another frame.
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     armed_d = 1'b0;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Odd parity wants an odd count of ones over data+pbit, even wants even.
   assign par_xor = ^{shreg_q, pbit_q};
   assign perr_w  = (PARITY == 0) ? 1'b0 :
                    (PARITY == 1) ? ~par_xor : par_xor;

   // One-entry output register: load on completion if empty or draining, else flag overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (done_q) begin
            if (!valid_q || rx_if.data_ready) begin
               dout_q     <= shreg_q;
               valid_q    <= 1'b1;
               perr_out_q <= perr_w;
               ferr_out_q <= ferr_q;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && rx_if.data_ready) begin
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
         end
      end
   end

   assign rx_if.data_out   = dout_q;
   assign rx_if.data_valid = valid_q;
   assign rx_if.parity_err = perr_out_q;
   assign rx_if.frame_err  = ferr_out_q;
   assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: even-parity receiver plus an odd-parity twin on the same line.
module tb_uart_rx_os;

   localparam int BITCLK = 64;   // 16 os_ticks per bit, one os_tick every 4 clocks

   logic clk = 1'b0;
   logic rst_n;
   logic rx_pin;
   logic os_tick;

   int checks   = 0;
   int failures = 0;

   uart_rx_os_if #(.DATA_BITS(8)) if_e ();
   uart_rx_os_if #(.DATA_BITS(8)) if_o ();

   uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_pin  (rx_pin),
      .os_tick (os_tick),
      .rx_if   (if_e)
   );

   uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_odd (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_pin  (rx_pin),
      .os_tick (os_tick),
      .rx_if   (if_o)
   );

   always #5 clk = ~clk;

   initial begin
      os_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         os_tick = 1'b1;
         @(negedge clk);
         os_tick = 1'b0;
      end
   end

   // Accepted frames as {data, parity_err, frame_err}.
   logic [9:0] q_e[$];
   logic [9:0] q_o[$];
   int valid_cycles = 0;
   int ovr_cnt      = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (if_e.data_valid) valid_cycles++;
         if (if_e.overrun) ovr_cnt++;
         if (if_e.data_valid && if_e.data_ready)
            q_e.push_back({if_e.data_out, if_e.parity_err, if_e.frame_err});
         if (if_o.data_valid && if_o.data_ready)
            q_o.push_back({if_o.data_out, if_o.parity_err, if_o.frame_err});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic b, input int nbits);
      rx_pin = b;
      repeat (BITCLK * nbits) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int idle_bits);
      drive(1'b0, 1);
      for (int i = 0; i < 8; i++) drive(d[i], 1);
      drive(p, 1);
      drive(s, 1);
      if (idle_bits > 0) drive(1'b1, idle_bits);
   endtask

   task automatic pop_e(input string name, input logic [7:0] ed, input logic ep, input logic ef);
      logic [9:0] e;
      if (q_e.size() == 0) begin
         chk({name, "_present"}, 0, 1);
      end else begin
         e = q_e.pop_front();
         chk({name, "_data"}, e[9:2], ed);
         chk({name, "_perr"}, e[1], ep);
         chk({name, "_ferr"}, e[0], ef);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       ep;
      logic       ef;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int vc0;
      int ov0;
      logic [9:0] e;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};

      rst_n           = 1'b0;
      rx_pin          = 1'b1;
      if_e.data_ready = 1'b1;
      if_o.data_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_outputs", {if_e.data_out, if_e.data_valid, if_e.parity_err, if_e.frame_err, if_e.overrun}, 0);
      rst_n = 1'b1;
      drive(1'b1, 2);

      // Table: each frame delivered once, valid for one clock with data_ready=1.
      for (int i = 0; i < 7; i++) begin
         vc0 = valid_cycles;
         send_frame(vecs[i].d, vecs[i].p, vecs[i].s, 2);
         chk($sformatf("vec%0d_valid_cycles", i), valid_cycles - vc0, 1);
         chk($sformatf("vec%0d_count", i), q_e.size(), 1);
         pop_e($sformatf("vec%0d", i), vecs[i].d, vecs[i].ep, vecs[i].ef);
      end

      // Odd-parity twin: 0x01 with pbit=0 is correct odd parity.
      q_o.delete();
      send_frame(8'h01, 1'b0, 1'b1, 2);
      pop_e("even_01", 8'h01, 1'b1, 1'b0);
      if (q_o.size() == 0) begin
         chk("odd_01_present", 0, 1);
      end else begin
         e = q_o.pop_front();
         chk("odd_01_data", e[9:2], 8'h01);
         chk("odd_01_perr", e[1], 1'b0);
      end

      // Glitch: 4 os_ticks low is rejected; receiver still takes the next frame.
      vc0 = valid_cycles;
      rx_pin = 1'b0;
      repeat (16) @(negedge clk);
      drive(1'b1, 3);
      chk("glitch_no_valid", valid_cycles - vc0, 0);
      chk("glitch_no_frame", q_e.size(), 0);
      send_frame(8'h33, 1'b0, 1'b1, 2);
      chk("after_glitch_count", q_e.size(), 1);
      pop_e("after_glitch", 8'h33, 1'b0, 1'b0);

      // Break: framing error then a 40-bit low line; exactly one more frame afterwards.
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      drive(1'b0, 40);
      drive(1'b1, 2);
      send_frame(8'h55, 1'b0, 1'b1, 2);
      chk("break_count", q_e.size(), 2);
      pop_e("break_3c", 8'h3C, 1'b0, 1'b1);
      pop_e("break_55", 8'h55, 1'b0, 1'b0);

      // Overrun: consumer stalled, second frame dropped with a one-clock pulse.
      if_e.data_ready = 1'b0;
      ov0 = ovr_cnt;
      send_frame(8'h11, 1'b0, 1'b1, 1);
      chk("ovr_first_valid", if_e.data_valid, 1'b1);
      chk("ovr_first_data", if_e.data_out, 8'h11);
      send_frame(8'h22, 1'b0, 1'b1, 1);
      chk("ovr_pulse_cycles", ovr_cnt - ov0, 1);
      chk("ovr_held_valid", if_e.data_valid, 1'b1);
      chk("ovr_held_data", if_e.data_out, 8'h11);
      @(negedge clk);
      #1 if_e.data_ready = 1'b1;
      @(negedge clk);
      chk("ovr_valid_dropped", if_e.data_valid, 1'b0);
      chk("ovr_queue_empty", q_e.size(), 0);
      drive(1'b1, 1);

      // Reset mid-frame: partial 0x77 is discarded, only 0x66 arrives.
      drive(1'b0, 1);
      drive(1'b1, 3);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_outputs", {if_e.data_out, if_e.data_valid, if_e.parity_err, if_e.frame_err, if_e.overrun}, 0);
      rx_pin = 1'b0;
      repeat (20) @(negedge clk);
      rx_pin = 1'b1;
      rst_n  = 1'b1;
      drive(1'b1, 3);
      chk("rst_no_frame", q_e.size(), 0);
      send_frame(8'h66, 1'b0, 1'b1, 2);
      chk("rst_count", q_e.size(), 1);
      pop_e("rst_66", 8'h66, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
